// File: rtl/systolic_pe_param.sv
// Parametrised systolic processing element: four-mode MAC cell with fixed-point
// scaling, optional saturation, valid/stall handshake and a sticky overflow flag.
module systolic_pe_param #(
   parameter int DATA_W   = 32,
   parameter int FRAC_W   = 0,
   parameter bit SATURATE = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] c_in,
   input  logic [DATA_W-1:0] x_in,
   input  logic [1:0]        s_in,
   input  logic              v_in,
   input  logic              clr_ovf,
   output logic [DATA_W-1:0] c_out,
   output logic [DATA_W-1:0] x_out,
   output logic [1:0]        s_out,
   output logic              v_out,
   output logic [DATA_W-1:0] p_out,
   output logic              ovf_out
);

   localparam int PW = 2 * DATA_W;
   localparam int SW = 2 * DATA_W + 1;

   typedef enum logic [1:0] {
      MAC_P = 2'b00,
      LOAD  = 2'b01,
      ACC   = 2'b10,
      DRAIN = 2'b11
   } mode_t;

   localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

   mode_t                   mode;
   logic [DATA_W-1:0]       p;
   logic [DATA_W-1:0]       mul_b;
   logic [DATA_W-1:0]       addend;
   logic signed [PW-1:0]    op_a;
   logic signed [PW-1:0]    op_b;
   logic signed [PW-1:0]    prod_full;
   logic signed [PW-1:0]    prod_shift;
   logic signed [SW-1:0]    sum;
   logic [SW-DATA_W:0]      sum_hi;
   logic                    out_of_range;
   logic [DATA_W-1:0]       result;
   logic                    ovf_hit;

   assign mode = mode_t'(s_in);

   // MAC_P multiplies by the stored p and adds x_in; LOAD/ACC multiply x_in and add p.
   always_comb begin
      mul_b  = x_in;
      addend = p;
      if (mode == MAC_P) begin
         mul_b  = p;
         addend = x_in;
      end
   end

   // Full-width signed product, scaled, then summed with one guard bit so no
   // intermediate wrap can hide an overflow.
   always_comb begin
      op_a       = PW'($signed(c_in));
      op_b       = PW'($signed(mul_b));
      prod_full  = op_a * op_b;
      prod_shift = prod_full >>> FRAC_W;
      sum        = SW'(prod_shift) + SW'($signed(addend));
      sum_hi     = sum[SW-1:DATA_W-1];
      out_of_range = !((&sum_hi) || !(|sum_hi));
      result     = sum[DATA_W-1:0];
      if (out_of_range && SATURATE)
         result = sum[SW-1] ? MIN_VAL : MAX_VAL;
   end

   assign ovf_hit = v_in && (mode != DRAIN) && out_of_range;

   always_ff @(posedge clk) begin
      if (!rst) begin
         c_out   <= '0;
         x_out   <= '0;
         s_out   <= '0;
         v_out   <= 1'b0;
         p       <= '0;
         ovf_out <= 1'b0;
      end else if (en) begin
         c_out <= c_in;
         s_out <= s_in;
         v_out <= v_in;
         if (v_in) begin
            unique case (mode)
               MAC_P: x_out <= result;
               LOAD: begin
                  x_out <= result;
                  p     <= x_in;
               end
               ACC: begin
                  x_out <= x_in;
                  p     <= result;
               end
               DRAIN: begin
                  x_out <= p;
                  p     <= '0;
               end
               default: ;
            endcase
         end
         // A fresh overflow takes priority over a clear request in the same cycle.
         ovf_out <= ovf_hit || (ovf_out && !clr_ovf);
      end
   end

   assign p_out = p;

endmodule

// File: tb/tb_systolic_pe_param.sv
// Directed self-checking bench for systolic_pe_param: four instances (8-bit saturating,
// 8-bit wrapping, 8-bit Q4 fixed point, 32-bit legacy) share one stimulus stream.
module tb_systolic_pe_param;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [31:0] c_val;
   logic [31:0] x_val;
   logic [1:0]  s_in;
   logic        v_in;
   logic        clr_ovf;
   logic [7:0]  c8;
   logic [7:0]  x8;

   int tests_run = 0;
   int tests_failed = 0;

   assign c8 = c_val[7:0];
   assign x8 = x_val[7:0];

   always #5 clk = ~clk;

   logic [7:0]  s_c, s_x, s_p, w_c, w_x, w_p, f_c, f_x, f_p;
   logic [1:0]  s_s, w_s, f_s, l_s;
   logic        s_v, s_o, w_v, w_o, f_v, f_o, l_v, l_o;
   logic [31:0] l_c, l_x, l_p;

   systolic_pe_param #(.DATA_W(8), .FRAC_W(0), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .en(en), .c_in(c8), .x_in(x8), .s_in(s_in), .v_in(v_in),
      .clr_ovf(clr_ovf), .c_out(s_c), .x_out(s_x), .s_out(s_s), .v_out(s_v),
      .p_out(s_p), .ovf_out(s_o));

   systolic_pe_param #(.DATA_W(8), .FRAC_W(0), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .en(en), .c_in(c8), .x_in(x8), .s_in(s_in), .v_in(v_in),
      .clr_ovf(clr_ovf), .c_out(w_c), .x_out(w_x), .s_out(w_s), .v_out(w_v),
      .p_out(w_p), .ovf_out(w_o));

   systolic_pe_param #(.DATA_W(8), .FRAC_W(4), .SATURATE(1'b1)) dut_fix (
      .clk(clk), .rst(rst), .en(en), .c_in(c8), .x_in(x8), .s_in(s_in), .v_in(v_in),
      .clr_ovf(clr_ovf), .c_out(f_c), .x_out(f_x), .s_out(f_s), .v_out(f_v),
      .p_out(f_p), .ovf_out(f_o));

   systolic_pe_param #(.DATA_W(32), .FRAC_W(0), .SATURATE(1'b1)) dut_leg (
      .clk(clk), .rst(rst), .en(en), .c_in(c_val), .x_in(x_val), .s_in(s_in), .v_in(v_in),
      .clr_ovf(clr_ovf), .c_out(l_c), .x_out(l_x), .s_out(l_s), .v_out(l_v),
      .p_out(l_p), .ovf_out(l_o));

   // Drives one cycle of inputs, then waits past the rising edge before any check.
   task automatic applyStimulus(input logic [1:0] mode, input logic [31:0] c,
                                input logic [31:0] x, input logic valid);
      s_in  = mode;
      c_val = c;
      x_val = x;
      v_in  = valid;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b1; clr_ovf = 1'b0;
      applyStimulus(2'b00, 32'd0, 32'd0, 1'b0);
      applyStimulus(2'b00, 32'd0, 32'd0, 1'b0);
      checkOutput("reset_x", {24'd0, s_x}, 32'd0);
      checkOutput("reset_p", {24'd0, s_p}, 32'd0);
      checkOutput("reset_ovf", {31'd0, s_o}, 32'd0);
      rst = 1'b1;

      // Legacy equivalence on the 32-bit cell
      applyStimulus(2'b01, 32'd3, 32'd5, 1'b1);
      checkOutput("leg_load_x", l_x, 32'd15);
      checkOutput("leg_load_p", l_p, 32'd5);
      applyStimulus(2'b00, 32'd2, 32'd7, 1'b1);
      checkOutput("leg_mac_x", l_x, 32'd17);
      checkOutput("leg_mac_p", l_p, 32'd5);

      // Empty p, then accumulate with a stall and an invalid cycle in the middle
      applyStimulus(2'b11, 32'd0, 32'd0, 1'b1);
      checkOutput("drain0_x", {24'd0, s_x}, 32'd5);
      checkOutput("drain0_p", {24'd0, s_p}, 32'd0);
      applyStimulus(2'b10, 32'd2, 32'd3, 1'b1);
      checkOutput("acc1_p", {24'd0, s_p}, 32'd6);
      checkOutput("acc1_x", {24'd0, s_x}, 32'd3);
      en = 1'b0;
      for (int i = 0; i < 3; i++) applyStimulus(2'b11, 32'd99, 32'd77, 1'b1);
      checkOutput("stall_p", {24'd0, s_p}, 32'd6);
      checkOutput("stall_x", {24'd0, s_x}, 32'd3);
      checkOutput("stall_c", {24'd0, s_c}, 32'd2);
      checkOutput("stall_s", {30'd0, s_s}, 32'd2);
      checkOutput("stall_v", {31'd0, s_v}, 32'd1);
      en = 1'b1;
      applyStimulus(2'b10, 32'd2, 32'd4, 1'b1);
      checkOutput("acc2_p", {24'd0, s_p}, 32'd14);
      checkOutput("acc2_x", {24'd0, s_x}, 32'd4);
      applyStimulus(2'b10, 32'd2, 32'd5, 1'b1);
      checkOutput("acc3_p", {24'd0, s_p}, 32'd24);
      checkOutput("acc3_x", {24'd0, s_x}, 32'd5);
      applyStimulus(2'b01, 32'd9, 32'd77, 1'b0);
      checkOutput("inval_p", {24'd0, s_p}, 32'd24);
      checkOutput("inval_x", {24'd0, s_x}, 32'd5);
      checkOutput("inval_c", {24'd0, s_c}, 32'd9);
      checkOutput("inval_s", {30'd0, s_s}, 32'd1);
      checkOutput("inval_v", {31'd0, s_v}, 32'd0);
      applyStimulus(2'b11, 32'd0, 32'd0, 1'b1);
      checkOutput("drain_x", {24'd0, s_x}, 32'd24);
      checkOutput("drain_p", {24'd0, s_p}, 32'd0);

      // Positive overflow: 127*2 = 254
      applyStimulus(2'b10, 32'd127, 32'd2, 1'b1);
      checkOutput("sat_p", {24'd0, s_p}, 32'h7F);
      checkOutput("sat_ovf", {31'd0, s_o}, 32'd1);
      checkOutput("sat_x", {24'd0, s_x}, 32'd2);
      checkOutput("wrap_p", {24'd0, w_p}, 32'hFE);
      checkOutput("wrap_ovf", {31'd0, w_o}, 32'd1);
      en = 1'b0; clr_ovf = 1'b1;
      applyStimulus(2'b00, 32'd0, 32'd0, 1'b0);
      checkOutput("clr_stalled", {31'd0, s_o}, 32'd1);
      en = 1'b1;
      applyStimulus(2'b00, 32'd0, 32'd0, 1'b0);
      checkOutput("clr_sat", {31'd0, s_o}, 32'd0);
      checkOutput("clr_wrap", {31'd0, w_o}, 32'd0);
      applyStimulus(2'b10, 32'd1, 32'd1, 1'b1);
      checkOutput("set_wins", {31'd0, s_o}, 32'd1);
      checkOutput("set_wins_p", {24'd0, s_p}, 32'h7F);
      clr_ovf = 1'b0;

      // Negative overflow: -128*2 = -256
      applyStimulus(2'b11, 32'd0, 32'd0, 1'b1);
      applyStimulus(2'b10, 32'hFFFF_FF80, 32'd2, 1'b1);
      checkOutput("sat_neg_p", {24'd0, s_p}, 32'h80);
      checkOutput("wrap_neg_p", {24'd0, w_p}, 32'h00);

      // Q4 fixed point: 1.5 * 2.0 + 0.5 = 3.5
      applyStimulus(2'b01, 32'd0, 32'h20, 1'b1);
      checkOutput("fix_load_p", {24'd0, f_p}, 32'h20);
      applyStimulus(2'b00, 32'h18, 32'h08, 1'b1);
      checkOutput("fix_mac_x", {24'd0, f_x}, 32'h38);
      applyStimulus(2'b01, 32'd0, 32'd1, 1'b1);
      applyStimulus(2'b00, 32'hFFFF_FFFF, 32'd0, 1'b1);
      checkOutput("fix_floor_x", {24'd0, f_x}, 32'hFF);

      // Mid-stream reset with en=1, then with en=0
      checkOutput("pre_reset_p", {24'd0, s_p}, 32'd1);
      rst = 1'b0;
      applyStimulus(2'b01, 32'd3, 32'd4, 1'b1);
      checkOutput("rst_en1_p", {24'd0, s_p}, 32'd0);
      checkOutput("rst_en1_x", {24'd0, s_x}, 32'd0);
      checkOutput("rst_en1_c", {24'd0, s_c}, 32'd0);
      checkOutput("rst_en1_v", {31'd0, s_v}, 32'd0);
      rst = 1'b1;
      applyStimulus(2'b01, 32'd3, 32'd4, 1'b1);
      checkOutput("reload_p", {24'd0, s_p}, 32'd4);
      rst = 1'b0; en = 1'b0;
      applyStimulus(2'b01, 32'd3, 32'd4, 1'b1);
      checkOutput("rst_en0_p", {24'd0, s_p}, 32'd0);
      checkOutput("rst_en0_c", {24'd0, s_c}, 32'd0);
      checkOutput("rst_en0_s", {30'd0, s_s}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
